// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - accumulate stage of the shift-add MAC (operand handshake, multiplier control, sum output)
// Optional: define MAC_ACC_SAT_EN to clamp the accumulator at all-ones instead of wrapping.
module mac_accumulator #(
   parameter int OP_W  = 8,
   parameter int ACC_W = 20,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   input  logic              in_last,
   output logic [OP_W-1:0]   mul_a,
   output logic [OP_W-1:0]   mul_b,
   output logic              begin_mul,
   input  logic              mul_done,
   input  logic [2*OP_W-1:0] product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_cnt,
   output logic              overflow
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_ACC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               begin_mul_q, begin_mul_d;
   logic               out_valid_q, out_valid_d;
   logic               overflow_q, overflow_d;
   logic               last_q, last_d;
   logic [OP_W-1:0]    mul_a_q, mul_a_d;
   logic [OP_W-1:0]    mul_b_q, mul_b_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W:0]     sum;

   // One spare bit on top of the accumulator captures the carry out.
   assign sum = {1'b0, acc_q} + (ACC_W+1)'(product);

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      begin_mul_d = begin_mul_q;
      out_valid_d = out_valid_q;
      overflow_d  = overflow_q;
      last_d      = last_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mul_a_d     = in_a;
               mul_b_d     = in_b;
               last_d      = in_last;
               in_ready_d  = 1'b0;
               begin_mul_d = 1'b1;
               state_d     = S_START;
            end
         end
         S_START: begin
            // Hold the request until the controller has visibly left idle.
            if (!mul_done) begin
               begin_mul_d = 1'b0;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            if (mul_done) state_d = S_ACC;
         end
         S_ACC: begin
`ifdef MAC_ACC_SAT_EN
            acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
            if (sum[ACC_W]) overflow_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            if (last_q) begin
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               in_ready_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               acc_d       = '0;
               cnt_d       = '0;
               overflow_d  = 1'b0;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            in_ready_d  = 1'b1;
            begin_mul_d = 1'b0;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         begin_mul_q <= 1'b0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         last_q      <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         begin_mul_q <= begin_mul_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         last_q      <= last_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign begin_mul = begin_mul_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign acc_out   = acc_q;
   assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator with a behavioural multiplier
module tb_mac_accumulator;
   localparam int OP_W  = 8;
   localparam int ACC_W = 16;
   localparam int CNT_W = 8;
   localparam longint MAXV = (64'd1 << ACC_W) - 1;
`ifdef MAC_ACC_SAT_EN
   localparam longint OVF_ACC = 65535;
`else
   localparam longint OVF_ACC = 64514;
`endif

   logic              clk, reset;
   logic              in_valid, in_ready, in_last;
   logic [OP_W-1:0]   in_a, in_b, mul_a, mul_b;
   logic              begin_mul, mul_done;
   logic [2*OP_W-1:0] product;
   logic              out_valid, out_ready, overflow;
   logic [ACC_W-1:0]  acc_out;
   logic [CNT_W-1:0]  term_cnt;

   int checks = 0, errors = 0;
   int terms_sent = 0, sums_taken = 0;
   int begin_rises = 0, valid_rises = 0;
   bit mul_busy = 0;

   mac_accumulator #(.OP_W(OP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_a(mul_a), .mul_b(mul_b), .begin_mul(begin_mul), .mul_done(mul_done), .product(product),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .term_cnt(term_cnt),
      .overflow(overflow)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Multiplier controller stand-in: one-cycle idle->init delay, variable run, garbage product while busy.
   initial begin
      logic [15:0] ma, mb;
      mul_done = 1;
      product  = '0;
      forever begin
         @(negedge clk);
         if (begin_mul === 1'b1) begin
            mul_busy = 1;
            ma = 16'(mul_a);
            mb = 16'(mul_b);
            @(negedge clk);
            mul_done = 0;
            product  = 16'($urandom);
            repeat ($urandom_range(3, 8)) @(negedge clk);
            product  = ma * mb;
            mul_done = 1;
            mul_busy = 0;
         end
      end
   end

   initial begin
      bit pb, pv;
      pb = 0;
      pv = 0;
      forever begin
         @(negedge clk);
         if (begin_mul === 1'b1 && !pb) begin_rises++;
         if (out_valid === 1'b1 && !pv) valid_rises++;
         pb = (begin_mul === 1'b1);
         pv = (out_valid === 1'b1);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last);
      int n = 0;
      while (in_ready !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > 500) begin
            check("send_timeout_in_ready", 64'(in_ready), 64'd1);
            return;
         end
      end
      in_valid = 1;
      in_a = a;
      in_b = b;
      in_last = last;
      @(negedge clk);
      in_valid = 0;
      in_last = 0;
      terms_sent++;
      check("mul_a_latched", 64'(mul_a), 64'(a));
      check("mul_b_latched", 64'(mul_b), 64'(b));
      check("in_ready_low_after_take", 64'(in_ready), 64'd0);
   endtask

   task automatic collect(input string tag, input longint ea, input int ec, input bit eo,
                          input int hold, input bit preready);
      int n = 0;
      logic [ACC_W-1:0] held;
      out_ready = preready;
      while (out_valid !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > 500) begin
            check({tag, "_timeout_out_valid"}, 64'(out_valid), 64'd1);
            out_ready = 0;
            return;
         end
      end
      check({tag, "_acc"}, 64'(acc_out), 64'(ea));
      check({tag, "_cnt"}, 64'(term_cnt), 64'(ec));
      check({tag, "_ovf"}, 64'(overflow), 64'(eo));
      check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      held = acc_out;
      if (!preready) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_acc"}, 64'(acc_out), 64'(held));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
         end
         out_ready = 1;
      end
      @(negedge clk);
      out_ready = 0;
      sums_taken++;
      check({tag, "_clr_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_clr_acc"}, 64'(acc_out), 64'd0);
      check({tag, "_clr_cnt"}, 64'(term_cnt), 64'd0);
      check({tag, "_clr_ovf"}, 64'(overflow), 64'd0);
      check({tag, "_clr_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      bit         last;
      int         hold;
      bit         preready;
      longint     exp_acc;
      int         exp_cnt;
      bit         exp_ovf;
   } vec_t;

   vec_t vecs[7];

   initial begin
      longint total;
      int     nt, waitn;
      logic [7:0] ra, rb;

      vecs[0] = '{8'd3,   8'd5,   1'b0, 0,  1'b1, 0,       0, 1'b0};
      vecs[1] = '{8'd7,   8'd9,   1'b1, 0,  1'b1, 78,      2, 1'b0};
      vecs[2] = '{8'd12,  8'd10,  1'b1, 10, 1'b0, 120,     1, 1'b0};
      vecs[3] = '{8'd255, 8'd255, 1'b0, 0,  1'b0, 0,       0, 1'b0};
      vecs[4] = '{8'd255, 8'd255, 1'b1, 0,  1'b0, OVF_ACC, 2, 1'b1};
      vecs[5] = '{8'd0,   8'd200, 1'b1, 2,  1'b0, 0,       1, 1'b0};
      vecs[6] = '{8'd1,   8'd1,   1'b1, 0,  1'b1, 1,       1, 1'b0};

      reset = 1;
      in_valid = 0;
      in_a = 0;
      in_b = 0;
      in_last = 0;
      out_ready = 0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_begin_mul", 64'(begin_mul), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_acc", 64'(acc_out), 64'd0);
      check("rst_cnt", 64'(term_cnt), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_mul_a", 64'(mul_a), 64'd0);
      reset = 0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].last);
         if (vecs[i].last)
            collect($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_cnt, vecs[i].exp_ovf,
                    vecs[i].hold, vecs[i].preready);
      end

      // Reset while the multiplier is running: the partial sum is lost and the late product ignored.
      send(8'd10, 8'd10, 1'b0);
      send(8'd100, 8'd100, 1'b0);
      waitn = 0;
      while (!(begin_mul === 1'b0 && mul_done === 1'b0) && waitn < 100) begin
         @(negedge clk);
         waitn++;
      end
      check("midrun_reached_run", 64'(waitn < 100), 64'd1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("midrun_in_ready", 64'(in_ready), 64'd1);
      check("midrun_begin_mul", 64'(begin_mul), 64'd0);
      check("midrun_acc", 64'(acc_out), 64'd0);
      check("midrun_cnt", 64'(term_cnt), 64'd0);
      waitn = 0;
      while (mul_busy && waitn < 100) begin
         @(negedge clk);
         waitn++;
      end
      repeat (3) @(negedge clk);
      check("late_product_acc", 64'(acc_out), 64'd0);
      check("late_product_valid", 64'(out_valid), 64'd0);
      check("late_product_in_ready", 64'(in_ready), 64'd1);

      // Term counter saturates at all-ones.
      for (int i = 0; i < 256; i++) send(8'd1, 8'd1, i == 255);
      collect("cnt_sat", 256, 255, 1'b0, 0, 1'b0);

      // Random sums against an arithmetic reference.
      for (int s = 0; s < 15; s++) begin
         nt = $urandom_range(1, 6);
         total = 0;
         for (int t = 0; t < nt; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 8'd255;
            total += longint'(ra) * longint'(rb);
            send(ra, rb, t == nt - 1);
         end
`ifdef MAC_ACC_SAT_EN
         collect($sformatf("rand%0d", s), (total > MAXV) ? MAXV : total, nt, total > MAXV,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
`else
         collect($sformatf("rand%0d", s), total % (MAXV + 1), nt, total > MAXV,
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
`endif
      end

      repeat (2) @(negedge clk);
      check("begin_mul_once_per_term", 64'(begin_rises), 64'(terms_sent));
      check("out_valid_once_per_sum", 64'(valid_rises), 64'(sums_taken));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
